// File: rtl/ifu_imem.sv
// Instruction memory with an AXI-like read-address/read-data interface, 4-deep in-order request FIFO
// and a fixed-latency response FSM. Optional macro IMEM_RANDOM_DELAY_EN adds LFSR-driven extra wait cycles.
module ifu_imem #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  syn_rst,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [63:0]           ifu_araddr,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [1:0]            ifu_rresp,
    output logic [31:0]           ifu_rdata,
    input  logic                  mem_we,
    input  logic [DEPTH_LOG2-1:0] mem_waddr,
    input  logic [31:0]           mem_wdata
);

    localparam int unsigned CNT_W = 5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_load;
    logic               pop, latch;

    logic [63:0]        fifo_q [4];
    logic [1:0]         wr_ptr, rd_ptr;
    logic [2:0]         count;
    logic               full, empty, push;
    logic [63:0]        cur_addr;

    logic [31:0]        mem [2**DEPTH_LOG2];
    logic [63:0]        off;
    logic [1:0]         dec_resp;
    logic [31:0]        dec_data;

    assign full        = (count == 3'd4);
    assign empty       = (count == 3'd0);
    assign ifu_arready = !full;
    assign push        = ifu_arvalid && !full;
    assign ifu_rvalid  = (state == S_RESP);

`ifdef IMEM_RANDOM_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (syn_rst) lfsr <= 8'hA5;
        else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        latch     = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop       = 1'b1;
                cnt_nxt   = cnt_load;
                state_nxt = S_WAIT;
            end
            S_WAIT: if (cnt == '0) begin
                latch     = 1'b1;
                state_nxt = S_RESP;
            end else begin
                cnt_nxt   = cnt - 1'b1;
            end
            S_RESP: if (ifu_rready) begin
                if (!empty) begin
                    pop       = 1'b1;
                    cnt_nxt   = cnt_load;
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Full is registered, so a pop in a full cycle cannot open a push slot until the next cycle.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= ifu_araddr;
        if (pop)  cur_addr       <= fifo_q[rd_ptr];
    end

    always_comb begin
        off      = cur_addr - BASE_ADDR;
        dec_resp = RESP_OKAY;
        dec_data = '0;
        if (cur_addr < BASE_ADDR || off >= (64'd4 << DEPTH_LOG2)) begin
            dec_resp = RESP_DECERR;
        end else if (cur_addr[1:0] != 2'b00) begin
            dec_resp = RESP_SLVERR;
        end else begin
            dec_data = mem[off[DEPTH_LOG2+1:2]];
        end
    end

    // Memory is not reset; the read above sees pre-write contents at a colliding edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            ifu_rresp <= RESP_OKAY;
            ifu_rdata <= '0;
        end else if (latch) begin
            ifu_rresp <= dec_resp;
            ifu_rdata <= dec_data;
        end
    end

endmodule

// File: tb/tb_ifu_imem.sv
// Self-checking bench for ifu_imem: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_ifu_imem;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [63:0] ifu_araddr;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [1:0]  ifu_rresp;
    logic [31:0] ifu_rdata;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [4096];

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs [8];

    ifu_imem #(.BASE_ADDR(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(1)) dut (
        .clk(clk), .syn_rst(syn_rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode straight from the address map rules.
    function automatic exp_t model_rd(input logic [63:0] a);
        exp_t e;
        e.resp = 2'b00;
        e.data = 32'h0;
        if (a < BASE || a >= BASE + 64'd4 * 64'd4096) e.resp = 2'b11;
        else if (a % 4 != 0)                          e.resp = 2'b10;
        else                                          e.data = ref_mem[(a - BASE) / 4];
        return e;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem_we    = 1'b1;
        mem_waddr = 12'(idx);
        mem_wdata = val;
        tick();
        mem_we    = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one request with an idle pipeline; lat counts edges from the AR handshake edge to rvalid.
    task automatic read_one(input logic [63:0] a, output logic [1:0] r, output logic [31:0] d, output int lat);
        int n = 0;
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        while (!ifu_arready && n < 100) begin tick(); n++; end
        tick();
        ifu_arvalid = 1'b0;
        lat = 1;
        while (!ifu_rvalid && lat < 100) begin tick(); lat++; end
        r = ifu_rresp;
        d = ifu_rdata;
    endtask

    task automatic finish_rsp();
        ifu_rready = 1'b1;
        tick();
        ifu_rready = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return BASE + 64'(4 * $urandom_range(0, 15));
            3:       return BASE + 64'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            4:       return BASE - 64'(4 * $urandom_range(1, 4));
            default: return BASE + 64'h4000 + 64'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          lat, n, acc, got, last;
        logic        hs_a, hs_r, stall;
        exp_t        e, prev;
        logic [63:0] a;

        syn_rst = 1'b1; ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        tick(); tick();
        check("rst_rvalid",  64'(ifu_rvalid),  64'd0);
        check("rst_arready", 64'(ifu_arready), 64'd1);
        check("rst_rresp",   64'(ifu_rresp),   64'd0);
        check("rst_rdata",   64'(ifu_rdata),   64'd0);
        syn_rst = 1'b0;
        tick();

        preload(0, 32'h0000_0413);
        preload(1, 32'h0000_0093);
        preload(4095, 32'h1234_5678);
        for (int i = 2; i < 16; i++) preload(i, $urandom);

        vecs[0] = '{64'h8000_0000, 2'b00, 32'h0000_0413};
        vecs[1] = '{64'h8000_0004, 2'b00, 32'h0000_0093};
        vecs[2] = '{64'h8000_3FFC, 2'b00, 32'h1234_5678};
        vecs[3] = '{64'h7FFF_FFFC, 2'b11, 32'h0};
        vecs[4] = '{64'h8000_0002, 2'b10, 32'h0};
        vecs[5] = '{64'h8000_4000, 2'b11, 32'h0};
        vecs[6] = '{64'h0000_0000, 2'b11, 32'h0};
        vecs[7] = '{64'h8000_4002, 2'b11, 32'h0};
        for (int i = 0; i < 8; i++) begin
            read_one(vecs[i].addr, r, d, lat);
            check($sformatf("vec%0d_lat", i),   64'(lat), 64'd3);
            check($sformatf("vec%0d_resp", i),  64'(r),   64'(vecs[i].resp));
            check($sformatf("vec%0d_data", i),  64'(d),   64'(vecs[i].data));
            finish_rsp();
            check($sformatf("vec%0d_drop", i),  64'(ifu_rvalid), 64'd0);
        end

        // Backpressure: response must hold for three stalled cycles.
        read_one(BASE + 64'd4, r, d, lat);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_rvalid", 64'(ifu_rvalid), 64'd1);
            check("bp_data",   {30'd0, ifu_rresp, ifu_rdata}, {30'd0, 2'b00, 32'h0000_0093});
        end
        finish_rsp();
        check("bp_done", 64'(ifu_rvalid), 64'd0);

        // Full FIFO: one request sits in the response stage, four more fill the FIFO.
        acc = 0; ifu_araddr = BASE; ifu_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hs_a = ifu_arvalid && ifu_arready;
            tick();
            if (hs_a) begin
                acc++;
                if (acc < 6) ifu_araddr = BASE + 64'(4 * acc);
                else         ifu_arvalid = 1'b0;
            end
        end
        check("full_accepted", 64'(acc), 64'd5);
        check("full_arready",  64'(ifu_arready), 64'd0);
        ifu_rready = 1'b1; got = 0; last = 0; n = 0;
        while (got < 6 && n < 100) begin
            hs_a = ifu_arvalid && ifu_arready;
            hs_r = ifu_rvalid && ifu_rready;
            r = ifu_rresp; d = ifu_rdata;
            tick(); n++;
            if (hs_a) begin acc++; ifu_arvalid = 1'b0; end
            if (hs_r) begin
                check($sformatf("full_rsp%0d", got), {30'd0, r, d}, {30'd0, 2'b00, ref_mem[got]});
                if (got > 0) check("thru_gap", 64'(n - last), 64'd2);
                last = n;
                got++;
            end
        end
        ifu_rready = 1'b0;
        check("full_got",  64'(got), 64'd6);
        check("full_acc6", 64'(acc), 64'd6);

        // Reset mid-flight drops everything queued.
        acc = 0; ifu_arvalid = 1'b1; n = 0;
        while (acc < 3 && n < 50) begin
            ifu_araddr = BASE + 64'(4 * acc);
            hs_a = ifu_arready;
            tick(); n++;
            if (hs_a) acc++;
        end
        ifu_arvalid = 1'b0;
        tick(); tick();
        syn_rst = 1'b1;
        tick();
        syn_rst = 1'b0;
        check("mrst_rvalid",  64'(ifu_rvalid),  64'd0);
        check("mrst_arready", 64'(ifu_arready), 64'd1);
        ifu_rready = 1'b1; n = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifu_rvalid) n++;
            tick();
        end
        ifu_rready = 1'b0;
        check("mrst_stale", 64'(n), 64'd0);

        // Write collision on the latching edge returns the old word.
        ifu_araddr = BASE; ifu_arvalid = 1'b1;
        tick();
        ifu_arvalid = 1'b0;
        tick();
        mem_we = 1'b1; mem_waddr = 12'd0; mem_wdata = 32'hDEAD_BEEF;
        tick();
        mem_we = 1'b0;
        ref_mem[0] = 32'hDEAD_BEEF;
        check("coll_rvalid", 64'(ifu_rvalid), 64'd1);
        check("coll_old",    64'(ifu_rdata),  64'h0000_0413);
        finish_rsp();
        read_one(BASE, r, d, lat);
        check("coll_new", 64'(d), 64'hDEAD_BEEF);
        finish_rsp();

        // Randomized traffic against the queue model.
        stall = 1'b0; prev = '0;
        for (int i = 0; i < 600; i++) begin
            if (stall) begin
                check("rnd_hold_v", 64'(ifu_rvalid), 64'd1);
                check("rnd_hold_d", {30'd0, ifu_rresp, ifu_rdata}, {30'd0, prev});
            end
            a = rand_addr();
            ifu_araddr  = a;
            ifu_arvalid = (i < 560) ? 1'($urandom_range(0, 1)) : 1'b0;
            ifu_rready  = ($urandom_range(0, 3) != 0) || (i >= 560);
            hs_a  = ifu_arvalid && ifu_arready;
            hs_r  = ifu_rvalid && ifu_rready;
            stall = ifu_rvalid && !ifu_rready;
            prev  = '{ifu_rresp, ifu_rdata};
            tick();
            if (hs_r) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_rsp", {30'd0, prev}, {30'd0, e});
                end
            end
            if (hs_a) exp_q.push_back(model_rd(a));
        end
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
